alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_mc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with optional restoring signed divider
//
// Purpose: single-cycle ADD/SUB/SLT/AND/OR plus, when ALU_MC_DIV_EN is defined,
// a signed restoring divider that takes WIDTH+2 cycles from start to done.
// Build macro: ALU_MC_DIV_EN (undefined -> no divider, DIV code is illegal).
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start             - operation request, sampled only while busy=0
//   alu_control       - 4-bit operation code
//   a, b              - operands (dividend, divisor for DIV)
//   result, remainder - registered results, held between done pulses
//   zero              - registered (result == 0)
//   busy              - divider in flight
//   done              - one-cycle pulse when outputs become valid
//   div_zero, illegal - status of the last completed operation
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1010;
`endif

    // Outcome of every operation that completes in one cycle, including
    // divide-by-zero, which never enters the iteration.
    logic [WIDTH-1:0] one_res;
    logic [WIDTH-1:0] one_rem;
    logic             one_dz;
    logic             one_ill;

    always_comb begin
        one_res = '0;
        one_rem = '0;
        one_dz  = 1'b0;
        one_ill = 1'b0;
        case (alu_control)
            OP_ADD: one_res = a + b;
            OP_SUB: one_res = a - b;
            OP_SLT: one_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_AND: one_res = a & b;
            OP_OR:  one_res = a | b;
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                one_res = '1;
                one_rem = a;
                one_dz  = 1'b1;
            end
`endif
            default: one_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_DIV_EN
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIV_RUN = 2'd1;
    localparam logic [1:0] DIV_FIX = 2'd2;
    localparam int         CW      = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    always_comb begin
        trial    = {rem, quo[WIDTH-1]};
        diff     = trial - {1'b0, dvs};
        q_bit    = ~diff[WIDTH];
        next_rem = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        fix_quo  = neg_q ? (~quo + 1'b1) : quo;
        fix_rem  = neg_r ? (~rem + 1'b1) : rem;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
            remainder <= '0;
            zero      <= 1'b1;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alu_control == OP_DIV && b != '0) begin
                            // Magnitudes of the most-negative value are
                            // still correct when read as unsigned.
                            quo   <= a[WIDTH-1] ? (~a + 1'b1) : a;
                            dvs   <= b[WIDTH-1] ? (~b + 1'b1) : b;
                            rem   <= '0;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                            count <= CW'(WIDTH);
                            state <= DIV_RUN;
                        end else begin
                            result    <= one_res;
                            remainder <= one_rem;
                            zero      <= (one_res == '0);
                            div_zero  <= one_dz;
                            illegal   <= one_ill;
                            done      <= 1'b1;
                        end
                    end
                end
                DIV_RUN: begin
                    rem   <= next_rem;
                    quo   <= {quo[WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= DIV_FIX;
                end
                DIV_FIX: begin
                    result    <= fix_quo;
                    remainder <= fix_rem;
                    zero      <= (fix_quo == '0);
                    div_zero  <= 1'b0;
                    illegal   <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy      = 1'b0;
    assign remainder = '0;
    assign div_zero  = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result  <= '0;
            zero    <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                result  <= one_res;
                zero    <= (one_res == '0);
                illegal <= one_ill;
                done    <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against an arithmetic reference model
module tb_alu_mc;

`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_DIV = 4'b1010;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_res;
    logic [31:0] exp_rem;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_control(alu_control),
        .a          (a),
        .b          (b),
        .result     (result),
        .remainder  (remainder),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Reference model: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] rm,
                                  output logic dz, output logic il, output int lat);
        longint sx;
        longint sy;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = 32'd0;
        rm  = 32'd0;
        dz  = 1'b0;
        il  = 1'b0;
        lat = 1;
        if (code == C_ADD)      r = 32'(sx + sy);
        else if (code == C_SUB) r = 32'(sx - sy);
        else if (code == C_SLT) r = (sx < sy) ? 32'd1 : 32'd0;
        else if (code == C_AND) r = x & y;
        else if (code == C_OR)  r = x | y;
        else if (code == C_DIV && DIV_EN) begin
            if (y == 32'd0) begin
                r  = 32'hFFFF_FFFF;
                rm = x;
                dz = 1'b1;
            end else begin
                r   = 32'(sx / sy);
                rm  = 32'(sx % sy);
                lat = 34;
            end
        end else il = 1'b1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ".result"},    result,    32'd0);
        check({tag, ".remainder"}, remainder, 32'd0);
        check({tag, ".zero"},      32'(zero),     32'd1);
        check({tag, ".busy"},      32'(busy),     32'd0);
        check({tag, ".done"},      32'(done),     32'd0);
        check({tag, ".div_zero"},  32'(div_zero), 32'd0);
        check({tag, ".illegal"},   32'(illegal),  32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge of the done cycle.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb);
        logic dz;
        logic il;
        int   lat;
        int   cyc;
        int   busy_cnt;
        model(code, x, y, exp_res, exp_rem, dz, il, lat);
        start = 1'b1;
        alu_control = code;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        alu_control = 4'($urandom);
        cyc = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (disturb && (cyc == 5 || cyc == 20)) begin
                start = 1'b1;
                alu_control = C_ADD;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, ".latency"},   32'(cyc), 32'(lat));
        check({tag, ".busy_cyc"},  32'(busy_cnt), 32'(lat - 1));
        check({tag, ".result"},    result, exp_res);
        check({tag, ".remainder"}, remainder, exp_rem);
        check({tag, ".zero"},      32'(zero), 32'(exp_res == 32'd0));
        check({tag, ".div_zero"},  32'(div_zero), 32'(dz));
        check({tag, ".illegal"},   32'(illegal), 32'(il));
        check({tag, ".busy"},      32'(busy), 32'd0);
    endtask

    task automatic hold_check(input string tag);
        @(negedge clk);
        check({tag, ".hold_done"},   32'(done), 32'd0);
        check({tag, ".hold_result"}, result, exp_res);
        check({tag, ".hold_rem"},    remainder, exp_rem);
    endtask

    initial begin
        logic [31:0] edge_vals [6];
        logic [3:0]  codes [7];
        int          seen_done;

        edge_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        codes     = '{C_ADD, C_SUB, C_SLT, C_AND, C_OR, C_DIV, 4'b1111};

        reset = 1'b1;
        start = 1'b0;
        alu_control = 4'd0;
        a = 32'd0;
        b = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        run_op("add_5_7", C_ADD, 32'd5, 32'd7, 1'b0);
        check("add_5_7.const", result, 32'd12);
        hold_check("add_5_7");
        run_op("sub_5_5", C_SUB, 32'd5, 32'd5, 1'b0);
        check("sub_5_5.zero", 32'(zero), 32'd1);
        run_op("slt_m1_1", C_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("slt_m1_1.const", result, 32'd1);
        run_op("and", C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        run_op("or", C_OR, 32'hF0F0_0000, 32'h0000_1234, 1'b0);
        run_op("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef ALU_MC_DIV_EN
        check("div_m7_2.q_const", result, 32'hFFFF_FFFD);
        check("div_m7_2.r_const", remainder, 32'hFFFF_FFFF);
`endif
        hold_check("div_m7_2");
        run_op("div_100_0", C_DIV, 32'd100, 32'd0, 1'b0);
        run_op("div_min_m1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_100_7_disturb", C_DIV, 32'd100, 32'd7, 1'b1);
`ifdef ALU_MC_DIV_EN
        check("div_100_7.q_const", result, 32'd14);
        check("div_100_7.r_const", remainder, 32'd2);
`endif
        run_op("illegal_1111", 4'b1111, 32'd3, 32'd4, 1'b0);
        run_op("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic [3:0]  c;
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 6)];
            x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = 32'($urandom_range(1, 20));
            run_op($sformatf("rand%0d", i), c, x, y, 1'b0);
        end

        // Reset in the middle of a division aborts it without a late done.
        start = 1'b1;
        alu_control = C_DIV;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("mid_reset.no_done", 32'(seen_done), 32'd0);
        run_op("add_after_reset", C_ADD, 32'd1, 32'd1, 1'b0);
        check("add_after_reset.const", result, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
